read_vels: RTL and testbench

Fetches the four face velocities (left, right, up, down) surrounding one pressure-field cell from the horizontal and vertical velocity BRAMs. It issues two read cycles and waits out the BRAM read latency. It returns the faces in the same vx1/vx2/vy1/vy2 slot order the velocity write-back path consumes. It sits between the cell-iteration controller and the divergence/projection arithmetic, as the read-side counterpart of velocity write-back.

---
 rtl/read_vels.sv | 158 +++++++++++++++
 tb/tb_read_vels.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/read_vels.sv
// Fetches the four face velocities around one pressure cell; build with READ_VELS_WALL_BOUND_EN to return walls at field edges.
// Latency: done pulses BRAM_LATENCY+2 cycles after start; one fetch per BRAM_LATENCY+2 cycles.
// No backpressure: start is only honoured in IDLE and is otherwise dropped, never queued.
module read_vels #(
    parameter int FIELD_WIDTH  = 8,
    parameter int FIELD_HEIGHT = 6,
    parameter int H_VEL_WIDTH  = FIELD_WIDTH - 1,
    parameter int H_VEL_SIZE   = H_VEL_WIDTH * FIELD_HEIGHT,
    parameter int V_VEL_WIDTH  = FIELD_WIDTH,
    parameter int V_VEL_SIZE   = V_VEL_WIDTH * (FIELD_HEIGHT - 1),
    parameter int VEL_DATAW    = 33,
    parameter int H_VEL_ADDRW  = $clog2(H_VEL_SIZE),
    parameter int V_VEL_ADDRW  = $clog2(V_VEL_SIZE),
    parameter int BRAM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            field_x,
    input  logic [31:0]            field_y,
    output logic [H_VEL_ADDRW-1:0] h_vel_addr_read,
    output logic [V_VEL_ADDRW-1:0] v_vel_addr_read,
    input  logic [VEL_DATAW-1:0]   h_vel_data_out,
    input  logic [VEL_DATAW-1:0]   v_vel_data_out,
    output logic [VEL_DATAW-1:0]   vx1,
    output logic [VEL_DATAW-1:0]   vx2,
    output logic [VEL_DATAW-1:0]   vy1,
    output logic [VEL_DATAW-1:0]   vy2,
    output logic                   busy,
    output logic                   done
);

    localparam logic [31:0] FW32 = 32'(FIELD_WIDTH);
    localparam logic [31:0] FH32 = 32'(FIELD_HEIGHT);
    localparam logic [31:0] HW32 = 32'(H_VEL_WIDTH);
    localparam logic [31:0] VW32 = 32'(V_VEL_WIDTH);

`ifdef READ_VELS_WALL_BOUND_EN
    localparam logic [VEL_DATAW-1:0] BOUND_VAL = {1'b1, {(VEL_DATAW-1){1'b0}}};
`else
    localparam logic [VEL_DATAW-1:0] BOUND_VAL = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE1,
        S_ISSUE2,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic act;
        logic side;
        logic vld_h;
        logic vld_v;
    } tag_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] x_q;
    logic [31:0] y_q;
    tag_t        tag_in;
    tag_t        tag_out;
    tag_t        tag_pipe [BRAM_LATENCY];

    logic out_of_range;
    logic vld_left;
    logic vld_right;
    logic vld_up;
    logic vld_down;

    assign out_of_range = (x_q >= FW32) || (y_q >= FH32);
    assign vld_left     = !out_of_range && (x_q != 32'd0);
    assign vld_right    = !out_of_range && (x_q != FW32 - 32'd1);
    assign vld_up       = !out_of_range && (y_q != 32'd0);
    assign vld_down     = !out_of_range && (y_q != FH32 - 32'd1);
    assign tag_out      = tag_pipe[BRAM_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ISSUE1;
            S_ISSUE1: state_nxt = S_ISSUE2;
            S_ISSUE2: state_nxt = S_WAIT;
            S_WAIT:   if (tag_out.act && !tag_out.side) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Invalid faces still issue (at address 0) so both sides keep fixed timing.
    always_comb begin
        h_vel_addr_read = '0;
        v_vel_addr_read = '0;
        tag_in          = '0;
        case (state)
            S_ISSUE1: begin
                tag_in = '{act: 1'b1, side: 1'b1, vld_h: vld_left, vld_v: vld_up};
                if (vld_left) h_vel_addr_read = H_VEL_ADDRW'((x_q - 32'd1) + y_q * HW32);
                if (vld_up)   v_vel_addr_read = V_VEL_ADDRW'(x_q + (y_q - 32'd1) * VW32);
            end
            S_ISSUE2: begin
                tag_in = '{act: 1'b1, side: 1'b0, vld_h: vld_right, vld_v: vld_down};
                if (vld_right) h_vel_addr_read = H_VEL_ADDRW'(x_q + y_q * HW32);
                if (vld_down)  v_vel_addr_read = V_VEL_ADDRW'(x_q + y_q * VW32);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BRAM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < BRAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            vx1  <= '0;
            vx2  <= '0;
            vy1  <= '0;
            vy2  <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) begin
                x_q  <= field_x;
                y_q  <= field_y;
                busy <= 1'b1;
            end
            if (tag_out.act) begin
                if (tag_out.side) begin
                    vx1 <= tag_out.vld_h ? h_vel_data_out : BOUND_VAL;
                    vy1 <= tag_out.vld_v ? v_vel_data_out : BOUND_VAL;
                end else begin
                    vx2  <= tag_out.vld_h ? h_vel_data_out : BOUND_VAL;
                    vy2  <= tag_out.vld_v ? v_vel_data_out : BOUND_VAL;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_read_vels.sv
// Directed bench for read_vels: BRAM model returns addr+100; a scoreboard checks each done against queued expectations.
module tb_read_vels;

    localparam int HAW = 6;
    localparam int VAW = 6;
    localparam int DW  = 33;

`ifdef READ_VELS_WALL_BOUND_EN
    localparam logic [DW-1:0] BND = 33'h1_0000_0000;
`else
    localparam logic [DW-1:0] BND = 33'h0;
`endif

    typedef struct {
        logic [DW-1:0] vx1;
        logic [DW-1:0] vx2;
        logic [DW-1:0] vy1;
        logic [DW-1:0] vy2;
        int            start_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [31:0]    field_x;
    logic [31:0]    field_y;
    logic [HAW-1:0] h_addr;
    logic [VAW-1:0] v_addr;
    logic [DW-1:0]  h_data;
    logic [DW-1:0]  v_data;
    logic [DW-1:0]  h_r1;
    logic [DW-1:0]  v_r1;
    logic [DW-1:0]  vx1, vx2, vy1, vy2;
    logic           busy;
    logic           done;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_run = 0;
    exp_t sb[$];

    read_vels dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .field_x         (field_x),
        .field_y         (field_y),
        .h_vel_addr_read (h_addr),
        .v_vel_addr_read (v_addr),
        .h_vel_data_out  (h_data),
        .v_vel_data_out  (v_data),
        .vx1             (vx1),
        .vx2             (vx2),
        .vy1             (vy1),
        .vy2             (vy2),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage BRAM: word = addr + 100.
    always @(posedge clk) begin
        h_r1   <= DW'(h_addr) + 33'd100;
        v_r1   <= DW'(v_addr) + 33'd100;
        h_data <= h_r1;
        v_data <= v_r1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_done: done with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("vx1", 64'(vx1), 64'(e.vx1));
                    check("vx2", 64'(vx2), 64'(e.vx2));
                    check("vy1", 64'(vy1), 64'(e.vy1));
                    check("vy2", 64'(vy2), 64'(e.vy2));
                    check("latency", 64'(cyc - e.start_cyc), 64'd4);
                    check("busy_cycles", 64'(busy_run), 64'd4);
                    check("busy_low_at_done", 64'(busy), 64'd0);
                end
                busy_run = 0;
            end
        end
    end

    // Call at a negedge while the DUT is idle; returns at the negedge in ISSUE2.
    task automatic issue(input int x, input int y,
                         input int h1, input int v1, input int h2, input int v2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input logic [DW-1:0] e3, input logic [DW-1:0] e4);
        exp_t e;
        e.vx1 = e1; e.vx2 = e2; e.vy1 = e3; e.vy2 = e4;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        field_x = 32'(x);
        field_y = 32'(y);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("h_addr_side1", 64'(h_addr), 64'(h1));
        check("v_addr_side1", 64'(v_addr), 64'(v1));
        @(negedge clk);
        check("h_addr_side0", 64'(h_addr), 64'(h2));
        check("v_addr_side0", 64'(v_addr), 64'(v2));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && (sb.size() != 0 || busy); i++) @(negedge clk);
        if (sb.size() != 0 || busy) begin
            n_total++;
            $display("FAIL idle_timeout: pending=%0d busy=%0b, expected empty and idle", sb.size(), busy);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; field_x = '0; field_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_haddr", 64'(h_addr), 64'd0);
        check("rst_vaddr", 64'(v_addr), 64'd0);
        check("rst_vels", 64'(vx1 | vx2 | vy1 | vy2), 64'd0);

        // Interior cell (3,2)
        issue(3, 2, 16, 11, 17, 19, 33'd116, 33'd117, 33'd111, 33'd119);
        @(negedge clk);
        check("wait_haddr", 64'(h_addr), 64'd0);
        check("wait_vaddr", 64'(v_addr), 64'd0);
        wait_idle();
        check("hold_vx1", 64'(vx1), 64'd116);

        // Corner (0,0): left/up are boundary
        issue(0, 0, 0, 0, 0, 0, BND, 33'd100, BND, 33'd100);
        wait_idle();

        // Corner (7,5): right/down are boundary
        issue(7, 5, 41, 39, 0, 0, 33'd141, BND, 33'd139, BND);
        wait_idle();

        // Out of range (8,0): all boundary
        issue(8, 0, 0, 0, 0, 0, BND, BND, BND, BND);
        wait_idle();

        // start held while busy is ignored
        issue(1, 1, 7, 1, 8, 9, 33'd107, 33'd108, 33'd101, 33'd109);
        field_x = 32'd5; field_y = 32'd3; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // start in the done cycle launches a second fetch
        issue(3, 2, 16, 11, 17, 19, 33'd116, 33'd117, 33'd111, 33'd119);
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check("done_seen_b2b", 64'(done), 64'd1);
        issue(2, 4, 29, 26, 30, 34, 33'd129, 33'd130, 33'd126, 33'd134);
        wait_idle();

        // Reset at E2 mid-fetch
        field_x = 32'd3; field_y = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_vx1", 64'(vx1), 64'd0);
        check("midrst_vx2", 64'(vx2), 64'd0);
        check("midrst_vy1", 64'(vy1), 64'd0);
        check("midrst_vy2", 64'(vy2), 64'd0);
        repeat (6) @(negedge clk);
        issue(6, 3, 26, 22, 27, 30, 33'd126, 33'd127, 33'd122, 33'd130);
        wait_idle();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
